// File: rtl/serial_adder.sv
// Bit-serial ripple adder (A = D + B), one full-adder slice plus a carry flop, LSB first.
// Latency: start accepted at edge k -> sum bits in the cycles after edges k..k+WIDTH-1, done after edge k+WIDTH.
// Backpressure: none; start is ignored while busy and accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, a, b, cin  operand pair and carry-in, latched on an accepted start
//   busy              high while bits are being processed
//   s_bit, s_valid    serial sum stream, LSB first, one bit per cycle
//   sum, cout, done   parallel result and carry-out, valid on the done pulse and held afterwards
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             s_bit,
  output logic             s_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Single full-adder slice working on the current LSBs of the shift registers.
  logic bit_d;
  logic carry_d;

  always_comb begin
    bit_d   = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    carry_d = (sh_a_q[0] & sh_b_q[0]) | (carry_q & (sh_a_q[0] ^ sh_b_q[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sh_a_q  <= a;
            sh_b_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          sum_q   <= {bit_d, sum_q[WIDTH-1:1]};
          sh_a_q  <= sh_a_q >> 1;
          sh_b_q  <= sh_b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          // A start in the done cycle chains straight into the next operation.
          if (start) begin
            sh_a_q  <= a;
            sh_b_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The serial bit is the slice output for the bit about to be committed. It is a
  // pure decode of flops (no input path), so bit 0 is presented in the cycle right
  // after the accepting edge and the last bit is gone by the time done rises.
  assign s_valid = busy_q;
  assign s_bit   = busy_q & bit_d;
  assign busy    = busy_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       s_bit;
  logic       s_valid;
  logic [7:0] sum;
  logic       cout;
  logic       done;

  int n_checks;
  int n_err;

  serial_adder #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .s_bit  (s_bit),
    .s_valid(s_valid),
    .sum    (sum),
    .cout   (cout),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation. pulse_mask[i]=1 raises start (with junk operands)
  // during RUN cycle i+1; those requests must be ignored.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic [7:0] esum, input logic ecout,
                        input logic [7:0] pulse_mask);
    logic [7:0] serial;
    int         vcnt;
    int         dcnt;
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = icin;
    tick();
    start  = 1'b0;
    serial = '0;
    vcnt   = 0;
    dcnt   = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_valid && busy) vcnt++;
      serial[i] = s_bit;
      if (done) dcnt++;
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      start = pulse_mask[i];
      tick();
    end
    start = 1'b0;
    check({tag, "_valid_cycles"}, vcnt, 8);
    check({tag, "_serial"}, serial, esum);
    check({tag, "_early_done"}, dcnt, 0);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_svalid_in_done"}, s_valid, 1'b0);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    tick();
    check({tag, "_done_single"}, done, 1'b0);
    check({tag, "_sum_held"}, sum, esum);
    check({tag, "_cout_held"}, cout, ecout);
  endtask

  // Full-subtractor cell cases (a, b, borrow-in) extended to 8 bits:
  // D = a - b - bin mod 256, and the expected carry-out of D + b + bin.
  logic [7:0] rt_a    [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
  logic [7:0] rt_b    [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
  logic       rt_bin  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] rt_d    [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'h00, 8'h00, 8'hFF};
  logic       rt_cout [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int dcnt;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_svalid", s_valid, 1'b0);
    check("rst_sbit", s_bit, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    rst = 1'b0;
    tick();

    // 5 + 3 = 8: serial stream 0,0,0,1,0,0,0,0.
    run_op("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 8'h00);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00);

    // The borrow-in goes back in as the carry-in: a = D + b + bin.
    for (int i = 0; i < 8; i++)
      run_op($sformatf("roundtrip%0d", i), rt_d[i], rt_b[i], rt_bin[i], rt_a[i], rt_cout[i], 8'h00);

    // start pulses during RUN cycles 3 and 5 are ignored: 0x12 + 0x34 = 0x46.
    run_op("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'b0001_0100);

    // Abort with reset mid-run; cout was left at 1 by the previous FF+FF+1 style case? make sure.
    run_op("pre_abort", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00);
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h11;
    cin   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    check("abort_svalid", s_valid, 1'b0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort_no_done", dcnt, 0);
    run_op("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00);

    // start held high: back-to-back 1 + 1, done every 9 cycles.
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    tick();
    for (int op = 0; op < 3; op++) begin
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (busy && !done) dcnt++;
        tick();
      end
      check($sformatf("b2b%0d_busy_run", op), dcnt, 8);
      check($sformatf("b2b%0d_done", op), done, 1'b1);
      check($sformatf("b2b%0d_busy_low", op), busy, 1'b0);
      check($sformatf("b2b%0d_sum", op), sum, 8'h02);
      if (op == 2) start = 1'b0;
      tick();
    end
    check("b2b_end_idle", busy, 1'b0);
    check("b2b_end_done", done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
